prog_seq_gen: RTL and testbench

Parametrised, programmable successor to the fixed 3-bit sequence generator. It steps through a run-time-writable table of `WIDTH`-bit codes, up to `DEPTH` entries long, in loop or one-shot mode, with step-enable, restart and a completion pulse. Reset loads the legacy sequence 000→010→011→101 in loop mode, so an instance with default parameters and `en` tied high is a drop-in replacement for the old generator. It sits in the stimulus/sequence path and feeds checkers or downstream datapaths.

---
 rtl/prog_seq_pkg.sv | 45 ++++
 rtl/seq_table.sv | 37 +++
 rtl/prog_seq_gen.sv | 128 ++++++++++++
 tb/tb_prog_seq_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types, legacy defaults and helpers for the programmable sequence generator.
package prog_seq_pkg;

    // Sequencer state: stepping through the table, or parked after a one-shot run.
    typedef enum logic {
        StRun  = 1'b0,
        StIdle = 1'b1
    } seq_state_e;

    // Legacy fixed-sequence codes loaded into table[0..3] at reset.
    localparam logic [2:0] SEQ_DEF0 = 3'b000;
    localparam logic [2:0] SEQ_DEF1 = 3'b010;
    localparam logic [2:0] SEQ_DEF2 = 3'b011;
    localparam logic [2:0] SEQ_DEF3 = 3'b101;

    // Legacy sequence length.
    localparam int unsigned LEN_DEF = 4;

    // Reset contents of table entry i; entries past the legacy four are zero.
    function automatic logic [2:0] def_code(input int unsigned i);
        logic [2:0] code;
        case (i)
            0:       code = SEQ_DEF0;
            1:       code = SEQ_DEF1;
            2:       code = SEQ_DEF2;
            3:       code = SEQ_DEF3;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // Map a requested length onto the legal range 1..depth.
    function automatic int unsigned clamp_len(input int unsigned req, input int unsigned depth);
        int unsigned len;
        if (req == 0) begin
            len = 1;
        end else if (req > depth) begin
            len = depth;
        end else begin
            len = req;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH code table: async reset to the legacy codes, one write port,
// one combinational read port.
module seq_table
    import prog_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage: reset restores the legacy table (zero-extended or truncated to WIDTH).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= WIDTH'(def_code(i));
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: no pipeline, so a write is visible the cycle after its edge.
    always_comb begin
        o_rd_data = r_mem[i_rd_addr];
    end

endmodule

// File: rtl/prog_seq_gen.sv
// Programmable sequence generator: steps through a writable code table in loop
// or one-shot mode. Default parameters with en tied high reproduce the legacy
// 000 -> 010 -> 011 -> 101 generator.
module prog_seq_gen
    import prog_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_start,
    input  logic             i_oneshot,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_len_we,
    input  logic [AW:0]      i_len_data,
    output logic [WIDTH-1:0] o_out,
    output logic [AW-1:0]    o_idx,
    output logic             o_busy,
    output logic             o_done
);

    // Elaboration-time parameter sanity.
    if (WIDTH < 1) begin : g_bad_width
        $error("prog_seq_gen: WIDTH must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("prog_seq_gen: DEPTH must be a power of two >= 4");
    end

    seq_state_e    r_state;
    seq_state_e    w_state_d;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_d;
    logic [AW:0]   r_len;
    logic [AW:0]   w_len_d;
    logic          r_done;
    logic          w_done_d;
    logic          w_last;

    seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (r_idx),
        .o_rd_data (o_out)
    );

    // Final-entry detect; >= so a shortened len leaving idx past the end still
    // takes the wrap/stop branch. r_len is never 0, so len-1 cannot underflow.
    always_comb begin
        w_last = ({1'b0, r_idx} >= (r_len - 1'b1));
    end

    // Next length: clamp requested value into 1..DEPTH.
    always_comb begin
        w_len_d = r_len;
        if (i_len_we) begin
            w_len_d = (AW + 1)'(clamp_len(32'(i_len_data), DEPTH));
        end
    end

    // Next state / index / done; start overrides any advance.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_done_d  = 1'b0;
        if (i_start) begin
            w_state_d = StRun;
            w_idx_d   = '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (i_en) begin
                        if (!w_last) begin
                            w_idx_d = r_idx + 1'b1;
                        end else if (!i_oneshot) begin
                            w_idx_d = '0;
                        end else begin
                            // One-shot end: park on the last entry and pulse done.
                            w_state_d = StIdle;
                            w_done_d  = 1'b1;
                        end
                    end
                end
                StIdle: begin
                    // en ignored; only start leaves IDLE.
                end
                default: begin
                    w_state_d = StRun;
                end
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StRun;
            r_idx   <= '0;
            r_len   <= (AW + 1)'(LEN_DEF);
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_len   <= w_len_d;
            r_done  <= w_done_d;
        end
    end

    // Outputs.
    always_comb begin
        o_idx  = r_idx;
        o_busy = (r_state == StRun);
        o_done = r_done;
    end

endmodule

// File: tb/tb_prog_seq_gen.sv
// Directed, table-driven bench for prog_seq_gen (WIDTH=4, DEPTH=8).
module tb_prog_seq_gen;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             start;
    logic             oneshot;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             len_we;
    logic [AW:0]      len_data;
    logic [WIDTH-1:0] out;
    logic [AW-1:0]    idx;
    logic             busy;
    logic             done;

    int n_tests;
    int n_fail;

    typedef struct {
        logic       en;
        logic       st;
        logic       os;
        logic       we;
        logic [2:0] wa;
        logic [3:0] wd;
        logic       lwe;
        logic [3:0] ld;
        logic [3:0] eo;
        logic [2:0] ei;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t vecs[$];

    prog_seq_gen #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_start    (start),
        .i_oneshot  (oneshot),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_len_we   (len_we),
        .i_len_data (len_data),
        .o_out      (out),
        .o_idx      (idx),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic s, input logic o, input logic w,
                                input logic [2:0] a, input logic [3:0] d, input logic l,
                                input logic [3:0] ld, input logic [3:0] eo,
                                input logic [2:0] ei, input logic eb, input logic ed);
        vec_t t;
        t.en = e; t.st = s; t.os = o; t.we = w; t.wa = a; t.wd = d;
        t.lwe = l; t.ld = ld; t.eo = eo; t.ei = ei; t.eb = eb; t.ed = ed;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eo, input logic [2:0] ei,
                             input logic eb, input logic ed);
        check({tag, ".out"},  {4'b0, out},  {4'b0, eo});
        check({tag, ".idx"},  {5'b0, idx},  {5'b0, ei});
        check({tag, ".busy"}, {7'b0, busy}, {7'b0, eb});
        check({tag, ".done"}, {7'b0, done}, {7'b0, ed});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; start = 0; oneshot = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        len_we = 0; len_data = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Legacy loop, then en toggled 1,0,0,1.
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: vecs.push_back(mk(1,0,0,0,0,0,0,0, 2,1,1,0));
                1: vecs.push_back(mk(1,0,0,0,0,0,0,0, 3,2,1,0));
                2: vecs.push_back(mk(1,0,0,0,0,0,0,0, 5,3,1,0));
                3: vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,0));
                4: vecs.push_back(mk(1,0,0,0,0,0,0,0, 2,1,1,0));
                default: vecs.push_back(mk(1,0,0,0,0,0,0,0, 3,2,1,0));
            endcase
        end
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 3,2,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 3,2,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 5,3,1,0));
        // One-shot stop at the last entry, en ignored in IDLE, then restart.
        vecs.push_back(mk(1,0,1,0,0,0,0,0, 5,3,0,1));
        vecs.push_back(mk(1,0,1,0,0,0,0,0, 5,3,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 2,1,1,0));
        // Program entries 1..8 with en low, len=6.
        vecs.push_back(mk(0,0,0,1,0,1,0,0, 2,1,1,0));
        vecs.push_back(mk(0,0,0,1,1,2,0,0, 2,1,1,0));
        vecs.push_back(mk(0,0,0,1,2,3,1,6, 2,1,1,0));
        for (int a = 3; a < 8; a++) begin
            vecs.push_back(mk(0,0,0,1,3'(a),4'(a + 1),0,0, 2,1,1,0));
        end
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,0,1,0));
        // Loop of length 6: 2,3,4,5,6,1,2.
        for (int a = 1; a <= 7; a++) begin
            vecs.push_back(mk(1,0,0,0,0,0,0,0, 4'((a % 6) + 1), 3'(a % 6), 1, 0));
        end
        // Write to the current entry, then write+advance to the same new entry.
        vecs.push_back(mk(0,0,0,1,1,4'hA,0,0, 4'hA,1,1,0));
        vecs.push_back(mk(1,0,0,1,2,4'hC,0,0, 4'hC,2,1,0));
        // len_data=15 clamps to 8: full 8-entry period.
        vecs.push_back(mk(1,0,0,0,0,0,1,15, 4,3,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 5,4,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 6,5,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 7,6,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 8,7,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,1,0));
        // len_data=0 clamps to 1 (start + len_we same edge): done per step in one-shot.
        vecs.push_back(mk(0,1,1,0,0,0,1,0, 1,0,1,0));
        vecs.push_back(mk(1,0,1,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,0,1,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,0,0,0, 1,0,1,0));
        vecs.push_back(mk(1,0,1,0,0,0,0,0, 1,0,0,1));
        // len=1 in loop mode: holds on entry 0, no done.
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,1,0));
        // Grow to 8, then shrink to 2 while idx is beyond it: next advance wraps.
        vecs.push_back(mk(1,0,0,0,0,0,1,8, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 4'hA,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 4'hC,2,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 4,3,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,2, 5,4,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 4'hA,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,1,0));

        // Reset state.
        idle_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        check_all("reset", 4'h0, 3'd0, 1'b1, 1'b0);

        // Table-driven section.
        foreach (vecs[i]) begin
            en = vecs[i].en; start = vecs[i].st; oneshot = vecs[i].os;
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            len_we = vecs[i].lwe; len_data = vecs[i].ld;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ei, vecs[i].eb, vecs[i].ed);
        end

        // Async reset mid-run at idx=2 after reprogramming.
        idle_inputs();
        start = 1; len_we = 1; len_data = 8;
        tick();
        start = 0; len_we = 0; en = 1;
        tick();
        tick();
        check_all("pre_rst", 4'hC, 3'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("mid_rst", 4'h0, 3'd0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        // Legacy table and length 4 restored: 2,3,5,0,2.
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_o;
            case (k % 4)
                0: exp_o = 4'h2;
                1: exp_o = 4'h3;
                2: exp_o = 4'h5;
                default: exp_o = 4'h0;
            endcase
            tick();
            check_all($sformatf("post_rst%0d", k), exp_o, 3'((k + 1) % 4), 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
